stack_engine: RTL and testbench

//  Parametrised 6502-style hardware stack unit. Executes multi-byte PUSH/POP
//  and SP-load commands over a valid/ready command port and a single-byte

---
 rtl/stack_engine.sv | 180 ++++++++++++++++++
 tb/tb_stack_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_engine.sv
`timescale 1ns/1ps
// 6502-style hardware stack unit: multi-byte PUSH/POP and SP load over a
// valid/ready command port, driving a single-byte memory master with ready handshake.
module stack_engine #(
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter logic [7:0] SP_RESET   = 8'hFF,
  parameter int         MAX_BYTES  = 2,
  parameter bit         WRAP_MODE  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [1:0]             cmd_len,
  input  logic [8*MAX_BYTES-1:0] cmd_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [8*MAX_BYTES-1:0] rsp_rdata,
  output logic [15:0]            mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_we,
  output logic                   mem_re,
  input  logic [7:0]             mem_rdata,
  input  logic                   mem_ready,
  output logic [7:0]             sp,
  output logic                   ovf_flag,
  output logic                   unf_flag,
  input  logic                   flag_clr
);

  localparam int         DW    = 8 * MAX_BYTES;
  localparam logic [2:0] MAX_B = 3'(MAX_BYTES);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      sp_q;
  logic [1:0]      op_q;
  logic            err_q;
  logic [DW-1:0]   data_q;
  logic [1:0]      byte_idx_q;
  logic [1:0]      beats_left_q;
  logic [DW-1:0]   pop_buf_q;
  logic [DW-1:0]   rdata_q;
  logic            ovf_q, unf_q;

  logic            accept;
  logic [2:0]      n_bytes;
  logic            len_bad;
  logic            range_bad;
  logic            cmd_bad;
  logic            beat_done;
  logic            last_beat;
  logic            ovf_set, unf_set;
  logic [DW-1:0]   pop_next;

  // Command decode and legality checks, evaluated on the live command fields
  always_comb begin
    accept    = cmd_valid && (state_q == S_IDLE);
    n_bytes   = {1'b0, cmd_len} + 3'd1;
    len_bad   = ({1'b0, cmd_len} >= MAX_B);
    range_bad = 1'b0;
    if (!WRAP_MODE) begin
      if (cmd_op == OP_PUSH && sp_q < {6'b0, cmd_len})
        range_bad = 1'b1;
      if (cmd_op == OP_POP && (SP_RESET - sp_q) < {5'b0, n_bytes})
        range_bad = 1'b1;
    end
    cmd_bad   = (cmd_op == OP_RSVD) || len_bad || range_bad;
    beat_done = (state_q == S_XFER) && mem_ready;
    last_beat = beat_done && (beats_left_q == 2'd0);
    ovf_set   = WRAP_MODE && beat_done && (op_q == OP_PUSH) && (sp_q == 8'h00);
    unf_set   = WRAP_MODE && beat_done && (op_q == OP_POP) && (sp_q == 8'hFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_bad || cmd_op == OP_LOAD) state_d = S_RESP;
          else                              state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (last_beat) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory master outputs; POP addresses the slot above sp (pre-increment read)
  always_comb begin
    mem_we    = (state_q == S_XFER) && (op_q == OP_PUSH);
    mem_re    = (state_q == S_XFER) && (op_q == OP_POP);
    mem_addr  = {STACK_PAGE, sp_q};
    mem_wdata = 8'h00;
    pop_next  = pop_buf_q;
    if (mem_re) mem_addr = {STACK_PAGE, sp_q + 8'd1};
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (byte_idx_q == 2'(i)) begin
        if (mem_we) mem_wdata = data_q[i*8 +: 8];
        pop_next[i*8 +: 8] = mem_rdata;
      end
    end
  end

  // Datapath: latch the command on accept, then step sp and byte index per beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q         <= SP_RESET;
      op_q         <= OP_PUSH;
      err_q        <= 1'b0;
      data_q       <= '0;
      byte_idx_q   <= 2'd0;
      beats_left_q <= 2'd0;
      pop_buf_q    <= '0;
      rdata_q      <= '0;
    end else begin
      if (accept) begin
        op_q         <= cmd_op;
        err_q        <= cmd_bad;
        data_q       <= cmd_wdata;
        beats_left_q <= cmd_len;
        byte_idx_q   <= (cmd_op == OP_PUSH) ? cmd_len : 2'd0;
        pop_buf_q    <= '0;
        if (!cmd_bad && cmd_op == OP_LOAD) sp_q <= cmd_wdata[7:0];
      end else if (beat_done) begin
        beats_left_q <= beats_left_q - 2'd1;
        if (op_q == OP_PUSH) begin
          sp_q       <= sp_q - 8'd1;
          byte_idx_q <= byte_idx_q - 2'd1;
        end else begin
          sp_q       <= sp_q + 8'd1;
          byte_idx_q <= byte_idx_q + 2'd1;
          pop_buf_q  <= pop_next;
          if (last_beat) rdata_q <= pop_next;
        end
      end
    end
  end

  // Sticky wrap flags; a set in the same cycle as flag_clr takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set)       ovf_q <= 1'b1;
      else if (flag_clr) ovf_q <= 1'b0;
      if (unf_set)       unf_q <= 1'b1;
      else if (flag_clr) unf_q <= 1'b0;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = (state_q == S_RESP) && err_q;
  assign rsp_rdata = rdata_q;
  assign sp        = sp_q;
  assign ovf_flag  = ovf_q;
  assign unf_flag  = unf_q;

endmodule

// File: tb/tb_stack_engine.sv
`timescale 1ns/1ps
// Directed bench for stack_engine: a wrapping instance (dut1) and a
// range-checked instance (dut0), each backed by a one-page memory model.
module tb_stack_engine;

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] RSVD = 2'b11;

  logic clk, rst_n;

  logic        cmd_valid1, cmd_ready1, rsp_valid1, rsp_err1;
  logic [1:0]  cmd_op1, cmd_len1;
  logic [15:0] cmd_wdata1, rsp_rdata1, mem_addr1;
  logic [7:0]  mem_wdata1, mem_rdata1, sp1;
  logic        mem_we1, mem_re1, mem_ready1, ovf1, unf1, flag_clr1;

  logic        cmd_valid0, cmd_ready0, rsp_valid0, rsp_err0;
  logic [1:0]  cmd_op0, cmd_len0;
  logic [15:0] cmd_wdata0, rsp_rdata0, mem_addr0;
  logic [7:0]  mem_wdata0, mem_rdata0, sp0;
  logic        mem_we0, mem_re0, mem_ready0, ovf0, unf0, flag_clr0;

  logic [7:0]  mem1 [256];
  logic [7:0]  mem0 [256];
  logic [23:0] wr_log1 [16];
  logic [15:0] rd_log1 [16];
  int          wr_cnt1 = 0;
  int          rd_cnt1 = 0;
  int          rsp_cnt1 = 0;
  int          wr_cnt0 = 0;

  int total = 0;
  int bad   = 0;

  stack_engine #(.STACK_PAGE(8'h01), .SP_RESET(8'hFF), .MAX_BYTES(2), .WRAP_MODE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_op(cmd_op1), .cmd_len(cmd_len1),
    .cmd_wdata(cmd_wdata1), .rsp_valid(rsp_valid1), .rsp_err(rsp_err1), .rsp_rdata(rsp_rdata1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_re(mem_re1),
    .mem_rdata(mem_rdata1), .mem_ready(mem_ready1), .sp(sp1),
    .ovf_flag(ovf1), .unf_flag(unf1), .flag_clr(flag_clr1)
  );

  stack_engine #(.STACK_PAGE(8'h01), .SP_RESET(8'hFF), .MAX_BYTES(2), .WRAP_MODE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_op(cmd_op0), .cmd_len(cmd_len0),
    .cmd_wdata(cmd_wdata0), .rsp_valid(rsp_valid0), .rsp_err(rsp_err0), .rsp_rdata(rsp_rdata0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0), .mem_re(mem_re0),
    .mem_rdata(mem_rdata0), .mem_ready(mem_ready0), .sp(sp0),
    .ovf_flag(ovf0), .unf_flag(unf0), .flag_clr(flag_clr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata1 = mem1[mem_addr1[7:0]];
  assign mem_rdata0 = mem0[mem_addr0[7:0]];

  // Memory models with beat logs, recorded only on completed handshakes
  always @(posedge clk) begin
    if (rst_n && mem_we1 && mem_ready1) begin
      mem1[mem_addr1[7:0]]  <= mem_wdata1;
      wr_log1[wr_cnt1[3:0]] <= {mem_addr1, mem_wdata1};
      wr_cnt1               <= wr_cnt1 + 1;
    end
    if (rst_n && mem_re1 && mem_ready1) begin
      rd_log1[rd_cnt1[3:0]] <= mem_addr1;
      rd_cnt1               <= rd_cnt1 + 1;
    end
    if (rst_n && rsp_valid1) rsp_cnt1 <= rsp_cnt1 + 1;
    if (rst_n && mem_we0 && mem_ready0) begin
      mem0[mem_addr0[7:0]] <= mem_wdata0;
      wr_cnt0              <= wr_cnt0 + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents one command for a single cycle; returns at the negedge after acceptance
  task automatic applyStimulus(input bit d0, input logic [1:0] op, input logic [1:0] len,
                               input logic [15:0] wdata);
    @(negedge clk);
    if (d0) begin
      cmd_op0 = op; cmd_len0 = len; cmd_wdata0 = wdata; cmd_valid0 = 1'b1;
    end else begin
      cmd_op1 = op; cmd_len1 = len; cmd_wdata1 = wdata; cmd_valid1 = 1'b1;
    end
    @(negedge clk);
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
  endtask

  // Counts cycles from acceptance (cycle 0) to rsp_valid, bounded at 40
  task automatic waitRsp(input bit d0, output int cyc, output logic err);
    cyc = 1;
    while (!(d0 ? rsp_valid0 : rsp_valid1) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    err = d0 ? rsp_err0 : rsp_err1;
  endtask

  initial begin
    int   cyc;
    logic err;
    int   wbase, rbase, rspbase;

    rst_n = 1'b0;
    cmd_valid1 = 0; cmd_op1 = 0; cmd_len1 = 0; cmd_wdata1 = 0; mem_ready1 = 1; flag_clr1 = 0;
    cmd_valid0 = 0; cmd_op0 = 0; cmd_len0 = 0; cmd_wdata0 = 0; mem_ready0 = 1; flag_clr0 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("rst_sp", 32'(sp1), 32'hFF);
    checkOutput("rst_ready", 32'(cmd_ready1), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    checkOutput("rst_we_re", 32'({mem_we1, mem_re1}), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr1), 32'h01FF);
    checkOutput("rst_wdata", 32'(mem_wdata1), 32'd0);
    checkOutput("rst_flags", 32'({ovf1, unf1}), 32'd0);
    checkOutput("rst_rdata", 32'(rsp_rdata1), 32'd0);

    // JSR-width push, MSB first
    wbase = wr_cnt1;
    applyStimulus(1'b0, PUSH, 2'd1, 16'hC0DE);
    waitRsp(1'b0, cyc, err);
    checkOutput("push2_lat", 32'(cyc), 32'd3);
    checkOutput("push2_err", 32'(err), 32'd0);
    checkOutput("push2_sp", 32'(sp1), 32'hFD);
    checkOutput("push2_nwr", 32'(wr_cnt1 - wbase), 32'd2);
    checkOutput("push2_wr0", 32'(wr_log1[wbase[3:0]]), 32'h01FFC0);
    checkOutput("push2_wr1", 32'(wr_log1[4'(wbase + 1)]), 32'h01FEDE);
    @(negedge clk);
    checkOutput("push2_ready", 32'(cmd_ready1), 32'd1);
    checkOutput("push2_pulse", 32'(rsp_valid1), 32'd0);

    // Matching pop returns the same 16-bit value
    rbase = rd_cnt1;
    applyStimulus(1'b0, POP, 2'd1, 16'h0000);
    waitRsp(1'b0, cyc, err);
    checkOutput("pop2_lat", 32'(cyc), 32'd3);
    checkOutput("pop2_err", 32'(err), 32'd0);
    checkOutput("pop2_rdata", 32'(rsp_rdata1), 32'hC0DE);
    checkOutput("pop2_sp", 32'(sp1), 32'hFF);
    checkOutput("pop2_rd0", 32'(rd_log1[rbase[3:0]]), 32'h01FE);
    checkOutput("pop2_rd1", 32'(rd_log1[4'(rbase + 1)]), 32'h01FF);

    // Stalled single-byte push: request held until mem_ready
    wbase = wr_cnt1;
    mem_ready1 = 1'b0;
    applyStimulus(1'b0, PUSH, 2'd0, 16'h0042);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready1 = 1'b1;
      checkOutput("stall_we", 32'(mem_we1), 32'd1);
      checkOutput("stall_addr", 32'(mem_addr1), 32'h01FF);
      checkOutput("stall_wdata", 32'(mem_wdata1), 32'h42);
      checkOutput("stall_sp", 32'(sp1), 32'hFF);
      @(negedge clk);
    end
    checkOutput("stall_rsp", 32'(rsp_valid1), 32'd1);
    checkOutput("stall_sp_after", 32'(sp1), 32'hFE);
    checkOutput("stall_nwr", 32'(wr_cnt1 - wbase), 32'd1);

    // Wrapping push across 00 sets ovf_flag
    applyStimulus(1'b0, LOAD, 2'd0, 16'h0000);
    waitRsp(1'b0, cyc, err);
    checkOutput("load_lat", 32'(cyc), 32'd1);
    checkOutput("load_err", 32'(err), 32'd0);
    checkOutput("load_sp", 32'(sp1), 32'h00);
    checkOutput("load_ovf", 32'(ovf1), 32'd0);
    wbase = wr_cnt1;
    applyStimulus(1'b0, PUSH, 2'd1, 16'hABCD);
    waitRsp(1'b0, cyc, err);
    checkOutput("wrap_wr0", 32'(wr_log1[wbase[3:0]]), 32'h0100AB);
    checkOutput("wrap_wr1", 32'(wr_log1[4'(wbase + 1)]), 32'h01FFCD);
    checkOutput("wrap_sp", 32'(sp1), 32'hFE);
    checkOutput("wrap_ovf", 32'(ovf1), 32'd1);
    flag_clr1 = 1'b1;
    @(negedge clk);
    flag_clr1 = 1'b0;
    checkOutput("clr_ovf", 32'(ovf1), 32'd0);

    // Wrapping pop across FF sets unf_flag
    applyStimulus(1'b0, POP, 2'd1, 16'h0000);
    waitRsp(1'b0, cyc, err);
    checkOutput("upop_rdata", 32'(rsp_rdata1), 32'hABCD);
    checkOutput("upop_sp", 32'(sp1), 32'h00);
    checkOutput("upop_unf", 32'(unf1), 32'd1);

    // Rejected commands: reserved op and oversize length
    applyStimulus(1'b0, RSVD, 2'd0, 16'h0055);
    waitRsp(1'b0, cyc, err);
    checkOutput("rsvd_lat", 32'(cyc), 32'd1);
    checkOutput("rsvd_err", 32'(err), 32'd1);
    checkOutput("rsvd_sp", 32'(sp1), 32'h00);
    wbase = wr_cnt1;
    applyStimulus(1'b0, PUSH, 2'd2, 16'h1111);
    waitRsp(1'b0, cyc, err);
    checkOutput("len_err", 32'(err), 32'd1);
    checkOutput("len_nwr", 32'(wr_cnt1 - wbase), 32'd0);
    checkOutput("len_rdata_held", 32'(rsp_rdata1), 32'hABCD);

    // Range-checked instance
    applyStimulus(1'b1, PUSH, 2'd1, 16'h1234);
    waitRsp(1'b1, cyc, err);
    checkOutput("nw_push_err", 32'(err), 32'd0);
    checkOutput("nw_push_sp", 32'(sp0), 32'hFD);
    applyStimulus(1'b1, POP, 2'd1, 16'h0000);
    waitRsp(1'b1, cyc, err);
    checkOutput("nw_pop_rdata", 32'(rsp_rdata0), 32'h1234);
    checkOutput("nw_pop_sp", 32'(sp0), 32'hFF);
    applyStimulus(1'b1, POP, 2'd0, 16'h0000);
    waitRsp(1'b1, cyc, err);
    checkOutput("nw_unf_lat", 32'(cyc), 32'd1);
    checkOutput("nw_unf_err", 32'(err), 32'd1);
    checkOutput("nw_unf_sp", 32'(sp0), 32'hFF);
    applyStimulus(1'b1, LOAD, 2'd0, 16'h0000);
    waitRsp(1'b1, cyc, err);
    checkOutput("nw_load_sp", 32'(sp0), 32'h00);
    wbase = wr_cnt0;
    applyStimulus(1'b1, PUSH, 2'd1, 16'h5678);
    waitRsp(1'b1, cyc, err);
    checkOutput("nw_ovf_err", 32'(err), 32'd1);
    checkOutput("nw_ovf_nwr", 32'(wr_cnt0 - wbase), 32'd0);
    checkOutput("nw_ovf_sp", 32'(sp0), 32'h00);
    applyStimulus(1'b1, PUSH, 2'd0, 16'h0099);
    waitRsp(1'b1, cyc, err);
    checkOutput("nw_edge_err", 32'(err), 32'd0);
    checkOutput("nw_edge_sp", 32'(sp0), 32'hFF);

    // Reset during the second beat of a pop
    applyStimulus(1'b0, LOAD, 2'd0, 16'h0010);
    waitRsp(1'b0, cyc, err);
    applyStimulus(1'b0, POP, 2'd1, 16'h0000);
    rspbase = rsp_cnt1;
    @(negedge clk);
    checkOutput("rst_mid_re", 32'(mem_re1), 32'd1);
    checkOutput("rst_mid_addr", 32'(mem_addr1), 32'h0112);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_sp", 32'(sp1), 32'hFF);
    checkOutput("rst_mid_re_off", 32'(mem_re1), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_mid_norsp", 32'(rsp_cnt1 - rspbase), 32'd0);
    checkOutput("rst_mid_ready", 32'(cmd_ready1), 32'd1);
    checkOutput("rst_mid_sp_after", 32'(sp1), 32'hFF);
    checkOutput("rst_mid_unf", 32'(unf1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
